// File: rtl/dct_pkg.sv
// Shared types and constants for the DA-based 1-D DCT row scheduler.
package dct_pkg;

  localparam int unsigned DW     = 12;
  localparam int unsigned DA_LAT = 6;
  localparam int unsigned NCOEF  = 8;

  typedef enum logic [2:0] {IDLE, BFLY, ISSUE, WAIT, CAPT} state_t;

  typedef logic signed [DW-1:0] sample_t;
  typedef sample_t [7:0]        row_t;

  // Signed add or subtract, clamped to the DW-bit two's complement range.
  function automatic sample_t sat_addsub(input sample_t a, input sample_t b, input logic sub);
    logic [DW:0] r;
    r = sub ? ({a[DW-1], a} - {b[DW-1], b}) : ({a[DW-1], a} + {b[DW-1], b});
    if (r[DW] != r[DW-1]) begin
      sat_addsub = r[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      sat_addsub = r[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/dct_in_pingpong.sv
// Two 8-sample input banks: one fills while the other waits for the butterfly.
module dct_in_pingpong
  import dct_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    wr_valid,
  input  sample_t wr_data,
  output logic    wr_ready,
  output logic    rd_full,
  output row_t    rd_row,
  input  logic    rd_free
);

  row_t       bank_q [2];
  logic [2:0] wr_ptr_q;
  logic       wr_bank_q;
  logic       rd_bank_q;
  logic [1:0] full_q;
  logic       wr_fire;
  logic       wr_done;

  assign wr_ready = ~(full_q[0] & full_q[1]);
  assign wr_fire  = wr_valid & wr_ready;
  assign wr_done  = wr_fire & (wr_ptr_q == 3'd7);
  assign rd_full  = full_q[rd_bank_q];
  assign rd_row   = bank_q[rd_bank_q];

  // Banks are consumed in fill order, so a write and a free never hit the same bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= 3'd0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + 3'd1;
      if (wr_done) begin
        wr_bank_q         <= ~wr_bank_q;
        full_q[wr_bank_q] <= 1'b1;
      end
      if (rd_free) begin
        rd_bank_q         <= ~rd_bank_q;
        full_q[rd_bank_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) bank_q[wr_bank_q][wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/dct_da_row_sched.sv
// Row scheduler: butterfly, eight serialized DA jobs, in-order coefficient stream.
module dct_da_row_sched
  import dct_pkg::*;
#(
  parameter int unsigned DW     = dct_pkg::DW,
  parameter int unsigned DA_LAT = dct_pkg::DA_LAT,
  parameter int unsigned NCOEF  = dct_pkg::NCOEF
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 da_start,
  output logic [2:0]           da_coef,
  output logic signed [DW-1:0] da_x0,
  output logic signed [DW-1:0] da_x1,
  output logic signed [DW-1:0] da_x2,
  output logic signed [DW-1:0] da_x3,
  input  logic signed [DW-1:0] da_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(DA_LAT);

  state_t        state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bank_free;
  logic          capt;
  logic          bank_full;
  row_t          row;

  sample_t       s_q [4];
  sample_t       d_q [4];
  sample_t       rbuf_q [8];
  logic [3:0]    wr_count_q;
  logic [2:0]    rd_ptr_q;
  logic          out_fire;
  logic          odd_k;

  dct_in_pingpong u_in (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .wr_valid (in_valid),
    .wr_data  (in_data),
    .wr_ready (in_ready),
    .rd_full  (bank_full),
    .rd_row   (row),
    .rd_free  (bank_free)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new row starts only once the previous row has fully drained downstream.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    bank_free = 1'b0;
    capt      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bank_full && (wr_count_q == 4'd0)) state_d = BFLY;
      end
      BFLY: begin
        bank_free = 1'b1;
        k_d       = 3'd0;
        state_d   = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CW'(DA_LAT - 2)) state_d = CAPT;
        else                          cnt_d   = cnt_q + CW'(1);
      end
      CAPT: begin
        capt = 1'b1;
        if (k_q == 3'(NCOEF - 1)) begin
          state_d = IDLE;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < 4; i++) begin
        s_q[i] <= '0;
        d_q[i] <= '0;
      end
    end else if (state_q == BFLY) begin
      for (int i = 0; i < 4; i++) begin
        s_q[i] <= sat_addsub(row[i], row[3'(7 - i)], 1'b0);
        d_q[i] <= sat_addsub(row[i], row[3'(7 - i)], 1'b1);
      end
    end
  end

  assign odd_k    = k_q[0];
  assign da_start = (state_q == ISSUE);
  assign da_coef  = k_q;
  assign da_x0    = odd_k ? d_q[0] : s_q[0];
  assign da_x1    = odd_k ? d_q[1] : s_q[1];
  assign da_x2    = odd_k ? d_q[2] : s_q[2];
  assign da_x3    = odd_k ? d_q[3] : s_q[3];
  assign busy     = (state_q != IDLE);

  assign out_valid = ({1'b0, rd_ptr_q} < wr_count_q);
  assign out_fire  = out_valid & out_ready;
  assign out_data  = out_valid ? rbuf_q[rd_ptr_q] : '0;
  assign out_last  = out_valid & (rd_ptr_q == 3'(NCOEF - 1));

  // Result buffer occupancy; consuming the last coefficient empties it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_count_q <= 4'd0;
      rd_ptr_q   <= 3'd0;
    end else if (out_fire && (rd_ptr_q == 3'(NCOEF - 1))) begin
      wr_count_q <= 4'd0;
      rd_ptr_q   <= 3'd0;
    end else begin
      if (capt)     wr_count_q <= wr_count_q + 4'd1;
      if (out_fire) rd_ptr_q   <= rd_ptr_q + 3'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (capt) rbuf_q[k_q] <= da_result;
  end

endmodule

// File: tb/tb_dct_da_row_sched.sv
// Directed bench for dct_da_row_sched with a fixed-latency DA core model.
module tb_dct_da_row_sched;

  localparam int unsigned DW     = 12;
  localparam int unsigned DA_LAT = 6;
  localparam int unsigned NCOEF  = 8;
  localparam logic signed [DW-1:0] GLITCH = 12'hBAD;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 da_start;
  logic [2:0]           da_coef;
  logic signed [DW-1:0] da_x0, da_x1, da_x2, da_x3;
  logic signed [DW-1:0] da_result = GLITCH;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_last;
  logic                 busy;

  dct_da_row_sched #(.DW(DW), .DA_LAT(DA_LAT), .NCOEF(NCOEF)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .da_start  (da_start),
    .da_coef   (da_coef),
    .da_x0     (da_x0),
    .da_x1     (da_x1),
    .da_x2     (da_x2),
    .da_x3     (da_x3),
    .da_result (da_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [7:0][DW-1:0] x;
    logic [7:0][DW-1:0] y;
    int                 chk_k;
    logic [DW-1:0]      chk_x0;
  } vec_t;

  vec_t vecs [6];
  int   ax [8];
  int   ay [8];

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int res_cyc = -100;
  logic signed [DW-1:0] res_val = '0;

  int bfly_count = 0;
  int bfly_cyc = 0;
  int acc_count = 0;
  int last_start = 0;
  int last_coef = 0;
  bit start_valid = 1'b0;
  bit prev_busy = 1'b0;
  logic signed [DW-1:0] held_x0 = '0;
  int x0_seen [8];
  int outq [$];
  bit lastq [$];
  int bflyq [$];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input int n, input int ck, input int cx);
    for (int i = 0; i < 8; i++) begin
      vecs[n].x[i] = DW'(ax[i]);
      vecs[n].y[i] = DW'(ay[i]);
    end
    vecs[n].chk_k  = ck;
    vecs[n].chk_x0 = DW'(cx);
  endtask

  // DA core model: result presented only in the DA_LAT-th cycle after a start.
  always @(posedge sys_clk) begin
    cyc++;
    #1;
    da_result = (cyc == res_cyc) ? res_val : GLITCH;
  end

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      start_valid = 1'b0;
      prev_busy   = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        bfly_count++;
        bfly_cyc = cyc;
        bflyq.push_back(cyc);
      end
      prev_busy = busy;
      if (out_valid && out_ready) begin
        outq.push_back(32'($signed(out_data)));
        lastq.push_back(out_last);
      end
      if (in_valid && in_ready) acc_count++;
      if (da_start) begin
        if (da_coef == 3'd0) begin
          check("first_start_after_bfly", cyc - bfly_cyc, 1);
        end else if (start_valid) begin
          check("start_spacing", cyc - last_start, DA_LAT + 1);
          check("coef_sequence", 32'(da_coef), last_coef + 1);
        end
        res_cyc  = cyc + DA_LAT;
        res_val  = DW'(int'(da_x0) + int'(da_x1) + int'(da_x2) + int'(da_x3) + int'(da_coef));
        last_start  = cyc;
        last_coef   = int'(da_coef);
        start_valid = 1'b1;
        held_x0     = da_x0;
        x0_seen[da_coef] = int'(da_x0);
      end else if (start_valid && (cyc - last_start <= DA_LAT)) begin
        check("operand_hold", 32'(da_x0), 32'(held_x0));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_row(input int v);
    for (int i = 0; i < 8; i++) begin
      int g;
      g        = 0;
      in_valid = 1'b1;
      in_data  = vecs[v].x[i];
      @(negedge sys_clk);
      while (!in_ready && g < 3000) begin
        @(negedge sys_clk);
        g++;
      end
      if (g >= 3000) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: row %0d sample %0d in_ready stayed 0", v, i);
      end
      @(posedge sys_clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n, input int budget);
    int g;
    g = 0;
    while (outq.size() < n && g < budget) begin
      tick(1);
      g++;
    end
    check("out_count", (outq.size() >= n) ? n : outq.size(), n);
  endtask

  task automatic check_row(input int v);
    for (int k = 0; k < 8; k++) begin
      if (outq.size() > 0) begin
        check($sformatf("row%0d_coef%0d", v, k), outq.pop_front(), 32'($signed(vecs[v].y[k])));
        check($sformatf("row%0d_last%0d", v, k), 32'(lastq.pop_front()), (k == 7) ? 1 : 0);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_data"}, 32'(out_data), 0);
    check({tag, "_out_last"}, 32'(out_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_da_start"}, 32'(da_start), 0);
    check({tag, "_da_coef"}, 32'(da_coef), 0);
    check({tag, "_da_x0"}, 32'(da_x0), 0);
    check({tag, "_da_x3"}, 32'(da_x3), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, n0, g;
    int d1, d2, d3;

    ax = '{100, 100, 100, 100, 100, 100, 100, 100};
    ay = '{800, 1, 802, 3, 804, 5, 806, 7};
    add_vec(0, 0, 200);
    ax = '{0, 1, 2, 3, 4, 5, 6, 7};
    ay = '{28, -15, 30, -13, 32, -11, 34, -9};
    add_vec(1, 1, -7);
    ax = '{2047, 0, 0, -8, -8, 0, 0, 2047};
    ay = '{2031, 1, 2033, 3, 2035, 5, 2037, 7};
    add_vec(2, 0, 2047);
    ax = '{-2048, 0, 0, 0, 0, 0, 0, 2047};
    ay = '{-1, -2047, 1, -2045, 3, -2043, 5, -2041};
    add_vec(3, 1, -2048);
    ax = '{10, -20, 30, -40, 50, -60, 70, -80};
    ay = '{-40, 1, -38, 3, -36, 5, -34, 7};
    add_vec(4, 1, 90);
    ax = '{0, -2048, 0, 0, 0, 0, -2048, 0};
    ay = '{-2048, 1, -2046, 3, -2044, 5, -2042, 7};
    add_vec(5, -1, 0);

    sys_rst   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #2;
    check_idle_outputs("reset");
    tick(3);
    sys_rst = 1'b0;
    tick(2);
    check_idle_outputs("post_reset");

    for (int v = 0; v < 6; v++) begin
      send_row(v);
      wait_outs(8, 200);
      check_row(v);
      if (vecs[v].chk_k >= 0)
        check($sformatf("row%0d_da_x0_k%0d", v, vecs[v].chk_k),
              x0_seen[vecs[v].chk_k], 32'($signed(vecs[v].chk_x0)));
    end

    // Backpressure: one row computes, two more fill the banks, nothing else moves.
    tick(4);
    out_ready = 1'b0;
    a0 = acc_count;
    n0 = bfly_count;
    fork
      begin
        send_row(0);
        send_row(1);
        send_row(4);
      end
    join_none
    tick(120);
    check("bp_accepted", acc_count - a0, 24);
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_bfly_count", bfly_count - n0, 1);
    check("bp_busy", 32'(busy), 0);
    check("bp_out_valid", 32'(out_valid), 1);
    check("bp_head", 32'(out_data), 800);
    out_ready = 1'b1;
    wait_outs(24, 400);
    check_row(0);
    check_row(1);
    check_row(4);
    tick(4);

    // Reset in the WAIT phase of k=3; the late DA result must not surface.
    send_row(1);
    g = 0;
    while (!(start_valid && last_coef == 3) && g < 200) begin
      tick(1);
      g++;
    end
    check("rst_reached_k3", (start_valid && last_coef == 3) ? 1 : 0, 1);
    tick(2);
    sys_rst = 1'b1;
    #1;
    check_idle_outputs("mid_row_reset");
    tick(2);
    sys_rst = 1'b0;
    tick(10);
    check("rst_late_out_valid", 32'(out_valid), 0);
    check("rst_late_busy", 32'(busy), 0);
    outq.delete();
    lastq.delete();
    send_row(5);
    wait_outs(8, 200);
    check_row(5);
    tick(4);

    // Continuous input: rows are compute-bound and arrive back to back.
    bflyq.delete();
    fork
      begin
        send_row(2);
        send_row(3);
        send_row(0);
        send_row(5);
      end
    join_none
    wait_outs(32, 600);
    check_row(2);
    check_row(3);
    check_row(0);
    check_row(5);
    check("tp_row_starts", bflyq.size(), 4);
    if (bflyq.size() >= 4) begin
      d1 = bflyq[1] - bflyq[0];
      d2 = bflyq[2] - bflyq[1];
      d3 = bflyq[3] - bflyq[2];
      check("tp_steady_12", d2, d1);
      check("tp_steady_23", d3, d2);
      check("tp_period_ge_compute", (d2 >= 1 + 8 * (DA_LAT + 1)) ? 1 : 0, 1);
    end
    tick(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
